// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the 2-read/1-write register file.
//   state_e : sweep-clear controller state (IDLE, SWEEP)
package regfile_pkg;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: access bus of the register file.
//   master drives : en, we, waddr, wdata, raddr0, raddr1, clr_req
//   slave drives  : rdata0, rdata1, busy, wr_drop
interface regfile_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             en;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr0;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             clr_req;
  logic             busy;
  logic             wr_drop;

  modport master (
    output en, we, waddr, wdata, raddr0, raddr1, clr_req,
    input  rdata0, rdata1, busy, wr_drop
  );
  modport slave (
    input  en, we, waddr, wdata, raddr0, raddr1, clr_req,
    output rdata0, rdata1, busy, wr_drop
  );
endinterface

// File: rtl/regfile_sweep_ctrl.sv
// regfile_sweep_ctrl: sequential clear engine. On clr_req in IDLE it walks
// cnt 0..DEPTH-1, one entry per enabled cycle, then returns to IDLE.
//   clk, clr_n   : clock, async active-low reset
//   en_i         : global enable, freezes the engine when low
//   clr_req_i    : sweep start request (ignored while sweeping)
//   busy_o       : registered, high while in SWEEP
//   clr_stb_o    : clear entry clr_addr_o on this edge
//   clr_addr_o   : entry being cleared
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          en_i,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic          clr_stb_o,
  output logic [AW-1:0] clr_addr_o
);
  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (en_i) begin
      case (state_q)
        IDLE: begin
          if (clr_req_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_stb_o  = en_i && busy_q;
  assign clr_addr_o = cnt_q;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: WIDTH x DEPTH register file, one write port, two registered
// read ports, optional write/clear-to-read bypass, global enable and a
// sweep-clear engine.
//   clk, clr_n : clock, async active-low reset (clears the whole array)
//   bus        : regfile_if slave (en, we, waddr, wdata, raddr0/1, clr_req
//                in; rdata0/1, busy, wr_drop out)
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH),
  parameter bit BYPASS = 1'b1
) (
  input  logic      clk,
  input  logic      clr_n,
  regfile_if.slave  bus
);
  logic                        busy;
  logic                        clr_stb;
  logic [AW-1:0]               clr_addr;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [1:0][WIDTH-1:0]       rdata_d, rdata_q;
  logic [1:0][AW-1:0]          raddr;
  logic                        wr_ok;
  logic                        wr_drop_q;

  regfile_sweep_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_sweep (
    .clk        (clk),
    .clr_n      (clr_n),
    .en_i       (bus.en),
    .clr_req_i  (bus.clr_req),
    .busy_o     (busy),
    .clr_stb_o  (clr_stb),
    .clr_addr_o (clr_addr)
  );

  assign raddr = {bus.raddr1, bus.raddr0};

  // Writes only land while idle; out-of-range addresses are silently dropped.
  assign wr_ok = bus.en && bus.we && !busy &&
                 ({1'b0, bus.waddr} < (AW+1)'(DEPTH));

  // Write and clear never coincide: a write needs !busy, a clear needs busy.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rdata_d[k] = '0;
      if ({1'b0, raddr[k]} < (AW+1)'(DEPTH)) begin
        rdata_d[k] = mem_q[raddr[k]];
        if (BYPASS) begin
          if (wr_ok && (bus.waddr == raddr[k]))
            rdata_d[k] = bus.wdata;
          else if (clr_stb && (clr_addr == raddr[k]))
            rdata_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem_q     <= '0;
      rdata_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      // Evaluated every cycle so the drop flag is a single-cycle pulse.
      wr_drop_q <= bus.en && bus.we && busy;
      if (bus.en) begin
        rdata_q <= rdata_d;
        if (wr_ok)   mem_q[bus.waddr] <= bus.wdata;
        if (clr_stb) mem_q[clr_addr]  <= '0;
      end
    end
  end

  assign bus.rdata0  = rdata_q[0];
  assign bus.rdata1  = rdata_q[1];
  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: three builds side by side -- A (DEPTH 8, bypass),
// B (DEPTH 8, no bypass), C (DEPTH 5, bypass). A hand-written table of
// vectors with fixed expectations, then multi-cycle sequences checked
// against a reference model through an expectation queue.
module tb_regfile_2r1w;
  localparam int W  = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic en; logic we; logic [2:0] waddr; logic [7:0] wdata;
    logic [2:0] raddr0; logic [2:0] raddr1; logic clr_req;
  } vin_t;
  typedef struct packed {
    logic [7:0] rd0; logic [7:0] rd1; logic busy; logic drop;
  } vout_t;
  typedef struct { int d; vin_t i; vout_t o; } tv_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b000;
  always #5 clk = ~clk;

  regfile_if #(.WIDTH(W), .AW(AW)) ifa ();
  regfile_if #(.WIDTH(W), .AW(AW)) ifb ();
  regfile_if #(.WIDTH(W), .AW(AW)) ifc ();

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1)) dut_a (.clk(clk), .clr_n(rst_n[0]), .bus(ifa));
  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b0)) dut_b (.clk(clk), .clr_n(rst_n[1]), .bus(ifb));
  regfile_2r1w #(.WIDTH(8), .DEPTH(5), .BYPASS(1'b1)) dut_c (.clk(clk), .clr_n(rst_n[2]), .bus(ifc));

  int    n_vec = 0;
  int    n_err = 0;
  vout_t q[$];

  // reference model state, one slot per build
  int         DEP[3] = '{8, 8, 5};
  bit         BYP[3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] m_mem [3][8];
  logic       m_busy[3];
  logic [2:0] m_cnt [3];
  vout_t      m_out [3];

  function automatic vin_t mk(logic en, logic we, logic [2:0] wa, logic [7:0] wd,
                              logic [2:0] r0, logic [2:0] r1, logic cr);
    return {en, we, wa, wd, r0, r1, cr};
  endfunction
  function automatic vout_t mo(logic [7:0] r0, logic [7:0] r1, logic b, logic dr);
    return {r0, r1, b, dr};
  endfunction

  task automatic drive(input int d, input vin_t v);
    case (d)
      0: begin ifa.en = v.en; ifa.we = v.we; ifa.waddr = v.waddr; ifa.wdata = v.wdata;
               ifa.raddr0 = v.raddr0; ifa.raddr1 = v.raddr1; ifa.clr_req = v.clr_req; end
      1: begin ifb.en = v.en; ifb.we = v.we; ifb.waddr = v.waddr; ifb.wdata = v.wdata;
               ifb.raddr0 = v.raddr0; ifb.raddr1 = v.raddr1; ifb.clr_req = v.clr_req; end
      default: begin ifc.en = v.en; ifc.we = v.we; ifc.waddr = v.waddr; ifc.wdata = v.wdata;
               ifc.raddr0 = v.raddr0; ifc.raddr1 = v.raddr1; ifc.clr_req = v.clr_req; end
    endcase
  endtask

  function automatic vout_t sample(int d);
    case (d)
      0:       return {ifa.rdata0, ifa.rdata1, ifa.busy, ifa.wr_drop};
      1:       return {ifb.rdata0, ifb.rdata1, ifb.busy, ifb.wr_drop};
      default: return {ifc.rdata0, ifc.rdata1, ifc.busy, ifc.wr_drop};
    endcase
  endfunction

  task automatic model_reset(input int d);
    for (int i = 0; i < 8; i++) m_mem[d][i] = 8'h00;
    m_busy[d] = 1'b0; m_cnt[d] = 3'd0; m_out[d] = '0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(input int d, input vin_t v, output vout_t e);
    logic       wr_ok, clr;
    logic [7:0] r[2];
    logic [2:0] ra[2];
    if (!v.en) begin
      m_out[d].drop = 1'b0;
      e = m_out[d];
      return;
    end
    ra[0] = v.raddr0; ra[1] = v.raddr1;
    wr_ok = v.we && !m_busy[d] && (int'(v.waddr) < DEP[d]);
    clr   = m_busy[d];
    for (int k = 0; k < 2; k++) begin
      if (int'(ra[k]) >= DEP[d])                        r[k] = 8'h00;
      else if (BYP[d] && wr_ok && v.waddr == ra[k])     r[k] = v.wdata;
      else if (BYP[d] && clr && m_cnt[d] == ra[k])      r[k] = 8'h00;
      else                                              r[k] = m_mem[d][ra[k]];
    end
    m_out[d].drop = v.we && m_busy[d];
    if (wr_ok) m_mem[d][v.waddr] = v.wdata;
    if (clr)   m_mem[d][m_cnt[d]] = 8'h00;
    if (!m_busy[d]) begin
      if (v.clr_req) begin m_busy[d] = 1'b1; m_cnt[d] = 3'd0; end
    end else if (int'(m_cnt[d]) == DEP[d] - 1) begin
      m_busy[d] = 1'b0; m_cnt[d] = 3'd0;
    end else begin
      m_cnt[d] = m_cnt[d] + 3'd1;
    end
    m_out[d].rd0 = r[0]; m_out[d].rd1 = r[1]; m_out[d].busy = m_busy[d];
    e = m_out[d];
  endtask

  task automatic chk(input string nm, input vout_t got, input vout_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got rd0=%h rd1=%h busy=%b drop=%b, want rd0=%h rd1=%h busy=%b drop=%b",
               nm, got.rd0, got.rd1, got.busy, got.drop, exp.rd0, exp.rd1, exp.busy, exp.drop);
    end
  endtask
  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  // Drive on the falling edge, queue the expectation, compare after the rising
  // edge, then park the port with en=0 so other builds can be exercised.
  task automatic step(input int d, input vin_t v, input bit use_tbl, input vout_t texp,
                      input string nm, output vout_t got);
    vout_t mexp, e;
    @(negedge clk);
    drive(d, v);
    model_step(d, v, mexp);
    q.push_back(use_tbl ? texp : mexp);
    @(posedge clk);
    #1;
    got = sample(d);
    e = q.pop_front();
    chk($sformatf("dut%0d %s", d, nm), got, e);
    drive(d, '0);
  endtask

  task automatic run(input int d, input vin_t v, input string nm, output vout_t got);
    step(d, v, 1'b0, '0, nm, got);
  endtask

  tv_t   tbl[$];
  vout_t g;
  int    nb;
  vout_t seen[16];

  initial begin
    drive(0, '0); drive(1, '0); drive(2, '0);
    for (int d = 0; d < 3; d++) model_reset(d);

    // reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("dut%0d reset", d), sample(d), '0);
    rst_n = 3'b111;

    // directed vectors with hand-derived expectations
    tbl.push_back('{0, mk(1,1,3,8'hBA,3,2,0), mo(8'hBA,8'h00,0,0)}); // bypass write
    tbl.push_back('{0, mk(0,1,4,8'h55,4,3,0), mo(8'hBA,8'h00,0,0)}); // en=0 frozen
    tbl.push_back('{0, mk(1,0,4,8'h55,4,3,0), mo(8'h00,8'hBA,0,0)}); // entry 4 untouched
    tbl.push_back('{0, mk(1,1,4,8'h55,3,4,0), mo(8'hBA,8'h55,0,0)}); // write now commits
    tbl.push_back('{0, mk(1,0,0,8'h00,4,0,0), mo(8'h55,8'h00,0,0)});
    tbl.push_back('{0, mk(1,0,0,8'h00,3,4,0), mo(8'hBA,8'h55,0,0)});
    tbl.push_back('{1, mk(1,1,3,8'hBA,3,0,0), mo(8'h00,8'h00,0,0)}); // no bypass: old value
    tbl.push_back('{1, mk(1,0,0,8'h00,3,0,0), mo(8'hBA,8'h00,0,0)}); // visible next edge
    tbl.push_back('{2, mk(1,1,6,8'h66,7,6,0), mo(8'h00,8'h00,0,0)}); // out of range
    tbl.push_back('{2, mk(1,1,4,8'h44,4,5,0), mo(8'h44,8'h00,0,0)});
    tbl.push_back('{2, mk(1,0,0,8'h00,4,6,0), mo(8'h44,8'h00,0,0)});
    foreach (tbl[t]) step(tbl[t].d, tbl[t].i, 1'b1, tbl[t].o, $sformatf("tbl%0d", t), g);

    // A: fill with 0xAA, read forward on port 0 and reversed on port 1
    for (int i = 0; i < 8; i++) run(0, mk(1,1,3'(i),8'hAA,0,0,0), "fill", g);
    for (int i = 0; i < 8; i++) begin
      run(0, mk(1,0,0,0,3'(i),3'(7-i),0), "readback", g);
      chk($sformatf("readback%0d", i), g, mo(8'hAA,8'hAA,0,0));
    end

    // A: sweep with a rejected write and two stalled cycles
    run(0, mk(1,0,0,0,0,7,1), "clr_req", g);
    nb = g.busy ? 1 : 0;
    begin : sweep_a
      for (int j = 0; j < 30; j++) begin
        run(0, mk((j == 4 || j == 5) ? 1'b0 : 1'b1, j == 2, 1, 8'h11, 3'(j), 7, 1),
            $sformatf("sweep%0d", j), g);
        if (j < 16) seen[j] = g;
        if (!g.busy) disable sweep_a;
        nb++;
      end
      chk_int("sweep A timeout", 0, 1);
    end
    chk_int("busy cycles A", nb, 10);
    chk_int("wr_drop pulse", int'(seen[2].drop), 1);
    chk_int("wr_drop clears", int'(seen[3].drop), 0);
    run(0, mk(1,1,2,8'h22,2,1,0), "write after busy", g);
    chk("write after busy", g, mo(8'h22,8'h00,0,0));
    for (int i = 0; i < 8; i++) run(0, mk(1,0,0,0,3'(i),3'(i),0), "post sweep", g);

    // A: reset three cycles into a sweep
    for (int i = 0; i < 8; i++) run(0, mk(1,1,3'(i),8'hAA,0,0,0), "refill", g);
    run(0, mk(1,0,0,0,0,0,1), "clr_req2", g);
    for (int j = 0; j < 3; j++) run(0, mk(1,0,0,0,7,6,0), "sweep pre-reset", g);
    rst_n[0] = 1'b0;
    #1;
    chk("async reset mid-sweep", sample(0), '0);
    model_reset(0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run(0, mk(1,0,0,0,3'(i),3'(7-i),0), "after reset", g);
      chk($sformatf("zero%0d", i), g, mo(8'h00,8'h00,0,0));
    end

    // B: sweep clearing the entry being read returns the old value first
    run(1, mk(1,1,5,8'h77,0,0,0), "b write", g);
    run(1, mk(1,0,0,0,5,0,1), "b clr_req", g);
    for (int k = 0; k < 8; k++) begin
      run(1, mk(1,0,0,0,5,0,0), $sformatf("b sweep%0d", k), g);
      seen[k] = g;
    end
    chk_int("B no-bypass clear old", int'(seen[5].rd0), 8'h77);
    chk_int("B cleared next", int'(seen[6].rd0), 8'h00);

    // C: five-entry sweep length
    for (int i = 0; i < 5; i++) run(2, mk(1,1,3'(i),8'hAA,0,0,0), "c fill", g);
    run(2, mk(1,0,0,0,7,3,1), "c clr_req", g);
    chk_int("C raddr 7 reads 0", int'(g.rd0), 0);
    nb = g.busy ? 1 : 0;
    begin : sweep_c
      for (int j = 0; j < 30; j++) begin
        run(2, mk(1,0,0,0,3'(j % 5),7,0), "c sweep", g);
        if (!g.busy) disable sweep_c;
        nb++;
      end
      chk_int("sweep C timeout", 0, 1);
    end
    chk_int("busy cycles C", nb, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised successor to the team's 8×8 register file. Provides WIDTH×DEPTH storage with one write port, two independent registered read ports, optional write-to-read bypass, a global enable, and a sequential sweep-clear engine that zeroes the array one entry per cycle under a busy flag. It sits in the lab datapath wherever the single-port register file was used, driven from switch inputs or a controller FSM.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 8, number of entries (≥2, need not be a power of 2)
- AW, $clog2(DEPTH), address width (derived; do not override)
- BYPASS, 1, 1 = same-cycle write forwarded to reads; 0 = reads return pre-write value

- clk  in  1  rising-edge clock
- clr_n  in  1  reset, asynchronous, active-low
- en  in  1  global enable; 0 freezes array, read registers and sweep
- we  in  1  write request
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr0, raddr1  in  AW  read addresses
- rdata0, rdata1  out  WIDTH  registered read data
- clr_req  in  1  start sweep-clear (level sampled at edge)
- busy  out  1  sweep in progress
- wr_drop  out  1  one-cycle pulse: write request rejected

## Operation
- Reset (clr_n=0, async): all entries, rdata0/1, wr_drop = 0; busy = 0; FSM IDLE; sweep counter 0.
- en=0: no state changes at all; outputs hold. Requests presented while en=0 are ignored (no wr_drop).
- Write (en=1): if we && state==IDLE && waddr<DEPTH → mem[waddr]<=wdata. waddr≥DEPTH → no write, no drop.
- Write while state==SWEEP (en=1, we=1) → no write, wr_drop=1 for the next cycle.
- Read (en=1): rdataK <= mem[raddrK]; raddrK≥DEPTH → 0.
- Bypass (BYPASS=1): if a write commits this edge to raddrK, rdataK <= wdata; if sweep clears entry raddrK this edge, rdataK <= 0. BYPASS=0: old content in both cases.
- FSM states IDLE, SWEEP.
  - IDLE→SWEEP: en && clr_req; counter<=0. A write in the same cycle still commits (and is later cleared).
  - SWEEP: each enabled edge mem[cnt]<=0, cnt<=cnt+1; when cnt==DEPTH-1 → IDLE, cnt<=0.
  - clr_req in SWEEP ignored; sweep does not restart.
- busy = (state==SWEEP), registered.

## Timing
- Read latency 1 cycle from address to rdata.
- Write visible on rdata the same edge with BYPASS=1, one edge later with BYPASS=0.
- busy rises the edge after clr_req is sampled, stays high exactly DEPTH enabled cycles; stretches by the number of en=0 cycles.
- First write accepted the edge busy is sampled 0.
- wr_drop high exactly one cycle per rejected request.
- Reset mid-sweep aborts immediately; array all-zero, IDLE, on clr_n assertion.

## Structure
- Package regfile_pkg: state enum {IDLE, SWEEP}; no other shared constants.
- Sub-module regfile_sweep_ctrl: FSM, AW-bit counter, busy, clear strobe and clear address. Top holds the array, read registers, bypass muxes, drop logic.

## Test plan
- Reset then write 0xAA to all 8 entries, read back each on rdata0, and its reverse order on rdata1 → matching 0xAA values one cycle after address.
- BYPASS=1: we=1, waddr=3, wdata=0xBA, raddr0=3 same cycle → rdata0=0xBA after that edge; BYPASS=0 build → old value, 0xBA one cycle later.
- en=0 with we=1, wdata=0x55 to entry 4 → entry 4 and rdata unchanged; en=1 → write commits.
- clr_req with array full of 0xAA → busy high exactly 8 cycles, entries read 0 progressively; write during busy → no write, wr_drop 1-cycle pulse; write right after busy falls → commits.
- clr_n pulled low at sweep cycle 3 → all outputs 0, busy 0 immediately; all entries read 0 after release.
- DEPTH=5 build: waddr=6 write ignored, raddr0=7 → rdata0=0; sweep busy = 5 cycles.
